// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle for the sequential shifter.
interface seq_shifter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, a, shamt, mode, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, shamt, mode, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL, up to STEP bits per cycle.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_shifter_if.slave bus,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic [SHW:0]     k;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    // k = min(rem, STEP); one extra bit so STEP == WIDTH fits
    always_comb begin
        k = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
        shifted = data_q;
        unique case (mode_q)
            2'b00: shifted = data_q << k;
            2'b01: shifted = data_q >> k;
            2'b10: shifted = $unsigned($signed(data_q) >>> k);
            2'b11: shifted = (data_q << k) | (data_q >> (WIDTH_W - k));
            default: shifted = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.a;
                    mode_d  = bus.mode;
                    rem_d   = bus.shamt;
                    state_d = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = shifted;
                rem_d  = rem_q - k[SHW-1:0];
                if (rem_d == '0) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = data_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances, vector table plus scoreboard.
module tb_seq_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv[2], ir[2], ov[2], ordy[2], bsy[2];
    logic [31:0] av[2], yv[2];
    logic [4:0]  nv[2];
    logic [1:0]  mv[2];

    seq_shifter_if #(.WIDTH(32), .SHW(5)) if0 ();
    seq_shifter_if #(.WIDTH(32), .SHW(5)) if1 ();

    assign if0.in_valid  = iv[0];
    assign if0.a         = av[0];
    assign if0.shamt     = nv[0];
    assign if0.mode      = mv[0];
    assign if0.out_ready = ordy[0];
    assign ir[0] = if0.in_ready;
    assign ov[0] = if0.out_valid;
    assign yv[0] = if0.y;

    assign if1.in_valid  = iv[1];
    assign if1.a         = av[1];
    assign if1.shamt     = nv[1];
    assign if1.mode      = mv[1];
    assign if1.out_ready = ordy[1];
    assign ir[1] = if1.in_ready;
    assign ov[1] = if1.out_valid;
    assign yv[1] = if1.y;

    seq_shifter #(.WIDTH(32), .SHW(5), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(bsy[0])
    );
    seq_shifter #(.WIDTH(32), .SHW(5), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(bsy[1])
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_y[$];
    int          sb_lat[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // bit-at-a-time reference, independent of the DUT's multi-bit steps
    function automatic logic [31:0] ref_sh(input logic [31:0] a,
                                           input int n,
                                           input logic [1:0] m);
        logic [31:0] r;
        r = a;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00: r = {r[30:0], 1'b0};
                2'b01: r = {1'b0, r[31:1]};
                2'b10: r = {r[31], r[31:1]};
                default: r = {r[30:0], r[31]};
            endcase
        end
        return r;
    endfunction

    task automatic run_op(input int sel, input logic [31:0] a,
                          input int n, input logic [1:0] m,
                          input int hold);
        int step;
        int lat;
        logic [31:0] ey;
        int el;
        step = (sel == 0) ? 1 : 4;
        @(negedge clk);
        chk("in_ready_idle", {31'b0, ir[sel]}, 32'd1);
        iv[sel] = 1'b1;
        av[sel] = a;
        nv[sel] = 5'(n);
        mv[sel] = m;
        sb_y.push_back(ref_sh(a, n, m));
        sb_lat.push_back(1 + (n + step - 1) / step);
        @(posedge clk);
        #1;
        iv[sel] = 1'b0;
        av[sel] = $urandom;
        nv[sel] = 5'($urandom);
        mv[sel] = 2'($urandom);
        lat = 1;
        while (!ov[sel] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ey = sb_y.pop_front();
        el = sb_lat.pop_front();
        if (!ov[sel]) begin
            chk("timeout_out_valid", 32'd0, 32'd1);
            return;
        end
        chk("result_y", yv[sel], ey);
        chk("latency", 32'(lat), 32'(el));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_y", yv[sel], ey);
            chk("hold_out_valid", {31'b0, ov[sel]}, 32'd1);
            chk("hold_in_ready", {31'b0, ir[sel]}, 32'd0);
        end
        @(negedge clk);
        ordy[sel] = 1'b1;
        @(posedge clk);
        #1;
        ordy[sel] = 1'b0;
        chk("drain_in_ready", {31'b0, ir[sel]}, 32'd1);
        chk("drain_out_valid", {31'b0, ov[sel]}, 32'd0);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] a;
        int          n;
        logic [1:0]  m;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; av[i] = '0;
            nv[i] = '0; mv[i] = '0;
        end
        vecs.push_back('{0, 32'h0000_0001, 2, 2'b00, 5});
        vecs.push_back('{0, 32'h8000_0000, 4, 2'b10, 0});
        vecs.push_back('{0, 32'h8000_0000, 4, 2'b01, 0});
        vecs.push_back('{0, 32'h8000_0001, 1, 2'b11, 0});
        vecs.push_back('{0, 32'h1234_5678, 8, 2'b11, 0});
        vecs.push_back('{1, 32'hFFFF_FFFF, 31, 2'b01, 0});
        vecs.push_back('{1, 32'hDEAD_BEEF, 0, 2'b00, 0});
        vecs.push_back('{1, 32'h8000_0000, 5, 2'b10, 0});
        vecs.push_back('{1, 32'h1234_5678, 8, 2'b11, 2});
        vecs.push_back('{0, 32'hCAFE_F00D, 0, 2'b11, 0});

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", {31'b0, ir[i]}, 32'd1);
            chk("rst_out_valid", {31'b0, ov[i]}, 32'd0);
            chk("rst_busy", {31'b0, bsy[i]}, 32'd0);
            chk("rst_y", yv[i], 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // spot-check the spec's literal results alongside the model
        chk("ref_sra", ref_sh(32'h8000_0000, 4, 2'b10), 32'hF800_0000);
        chk("ref_rol", ref_sh(32'h1234_5678, 8, 2'b11), 32'h3456_7812);

        foreach (vecs[i])
            run_op(vecs[i].sel, vecs[i].a, vecs[i].n, vecs[i].m, vecs[i].hold);

        // abort at the 5th SHIFT cycle of a 20-bit shift
        @(negedge clk);
        iv[0] = 1'b1; av[0] = 32'h0000_0001; nv[0] = 5'd20; mv[0] = 2'b00;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy", {31'b0, bsy[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, ov[0]}, 32'd0);
        chk("abort_y", yv[0], 32'd0);
        chk("abort_busy", {31'b0, bsy[0]}, 32'd0);
        chk("abort_in_ready", {31'b0, ir[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("abort_hold_ov", {31'b0, ov[0]}, 32'd0);
        rst_n = 1'b1;
        run_op(0, 32'hA5A5_0F0F, 7, 2'b11, 0);

        for (int i = 0; i < 24; i++)
            run_op(i % 2, $urandom, int'($urandom_range(0, 31)),
                   2'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
